// File: rtl/data_if_rx.sv
// Serial receiver for the single-wire data_if stream: start bit, WIDTH data bits LSB first,
// STOP_BITS stop bits. Define DATA_IF_RX_PARITY_EN to add an even-parity bit and parity_err.
module data_if_rx #(
  parameter int WIDTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
`ifdef DATA_IF_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

`ifdef DATA_IF_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_in;
  logic             stop_bad;
  logic             stop_fail;
`ifdef DATA_IF_RX_PARITY_EN
  logic             par_bad;
`endif

  // Right shift with the new bit at the MSB; written as shifts so WIDTH=1 stays legal.
  assign shift_in  = (shift >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign stop_fail = stop_bad | ~d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      stop_bad  <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef DATA_IF_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef DATA_IF_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!d) begin
            state <= DATA;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          shift <= shift_in;
          if (cnt == LAST_DATA) begin
            cnt      <= '0;
            stop_bad <= 1'b0;
`ifdef DATA_IF_RX_PARITY_EN
            state    <= PARITY;
`else
            state    <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef DATA_IF_RX_PARITY_EN
        PARITY: begin
          par_bad <= d ^ (^shift);
          state   <= STOP;
        end
`endif
        STOP: begin
          if (cnt == LAST_STOP) begin
            cnt <= '0;
            // Frame error wins over parity error; the line may still be held low.
            if (stop_fail) begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
`ifdef DATA_IF_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
`endif
            end else begin
              valid <= 1'b1;
              data  <= shift;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            stop_bad <= stop_fail;
            cnt      <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (d) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_if_rx.sv
// Scoreboard bench for data_if_rx: two instances (STOP_BITS=1 and 2) with queued expectations.
module tb_data_if_rx;

  typedef struct {
    int         kind;   // 0 valid, 1 frame_err, 2 parity_err
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d0 = 1'b1;
  logic       d1 = 1'b1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, fe0, fe1, busy0, busy1;
  logic       pe0, pe1;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       q0[$];
  exp_t       q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_if_rx #(.WIDTH(8), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .d(d0), .data(data0), .valid(valid0),
    .frame_err(fe0), .busy(busy0)
`ifdef DATA_IF_RX_PARITY_EN
    , .parity_err(pe0)
`endif
  );

  data_if_rx #(.WIDTH(8), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .data(data1), .valid(valid1),
    .frame_err(fe1), .busy(busy1)
`ifdef DATA_IF_RX_PARITY_EN
    , .parity_err(pe1)
`endif
  );

`ifndef DATA_IF_RX_PARITY_EN
  assign pe0 = 1'b0;
  assign pe1 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor side: pops one expectation per output pulse.
  task automatic check_out(input int sel, input logic v, input logic fe, input logic pe,
                           input logic [7:0] dat);
    exp_t e;
    int   kind;
    if (int'(v) + int'(fe) + int'(pe) > 1) begin
      vectors++;
      miscompares++;
      $display("FAIL pulses_overlap dut%0d: valid=%b frame_err=%b parity_err=%b expected one", sel, v, fe, pe);
    end
    if (v || fe || pe) begin
      if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse dut%0d: valid=%b frame_err=%b parity_err=%b at cycle %0d, expected none",
                 sel, v, fe, pe, cyc);
      end else begin
        e    = (sel == 0) ? q0.pop_front() : q1.pop_front();
        kind = v ? 0 : (fe ? 1 : 2);
        chk($sformatf("pulse_kind_dut%0d", sel), kind, e.kind);
        chk($sformatf("pulse_cycle_dut%0d", sel), cyc, e.cyc);
        chk($sformatf("pulse_data_dut%0d", sel), {24'd0, dat}, {24'd0, e.data});
      end
    end
  endtask

  always @(negedge clk) if (rst_n) check_out(0, valid0, fe0, pe0, data0);
  always @(negedge clk) if (rst_n) check_out(1, valid1, fe1, pe1, data1);

  task automatic drive(input int sel, input logic b);
    @(posedge clk);
    #1;
    if (sel == 0) d0 = b;
    else d1 = b;
  endtask

  // Stimulus side: sends one frame and queues the pulse it should produce.
  task automatic send(input int sel, input logic [7:0] w, input logic [1:0] stops,
                      input logic par_flip, input int kind, input logic [7:0] exp_data);
    exp_t e;
    int   nstop;
    int   par;
    nstop = (sel == 0) ? 1 : 2;
    par   = 0;
`ifdef DATA_IF_RX_PARITY_EN
    par = 1;
`endif
    drive(sel, 1'b0);
    e.kind = kind;
    e.data = exp_data;
    e.cyc  = cyc + 1 + 8 + par + nstop;
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
    for (int i = 0; i < 8; i++) drive(sel, w[i]);
`ifdef DATA_IF_RX_PARITY_EN
    drive(sel, (^w) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity support");
`endif
    for (int i = 0; i < nstop; i++) drive(sel, stops[i]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", {24'd0, data0}, 32'h0);
    chk("reset_busy", {31'd0, busy0}, 32'h0);
    chk("reset_valid", {31'd0, valid0}, 32'h0);
    chk("reset_frame_err", {31'd0, fe0}, 32'h0);
    rst_n = 1'b1;

    // Idle line: nothing happens.
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy0}, 32'h0);
    chk("idle_data", {24'd0, data0}, 32'h0);

    send(0, 8'hA5, 2'b11, 1'b0, 0, 8'hA5);
    drive(0, 1'b1);
    #1;
    chk("a5_busy_after", {31'd0, busy0}, 32'h0);
    chk("a5_data", {24'd0, data0}, 32'hA5);

    // Back-to-back frames, no gap.
    send(0, 8'h3C, 2'b11, 1'b0, 0, 8'h3C);
    send(0, 8'hC3, 2'b11, 1'b0, 0, 8'hC3);

    // Bad stop bit, then break held low.
    send(0, 8'h55, 2'b00, 1'b0, 1, 8'hC3);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0);
      #1;
      chk("break_busy", {31'd0, busy0}, 32'h1);
    end
    chk("break_data_held", {24'd0, data0}, 32'hC3);
    drive(0, 1'b1);
    send(0, 8'h0F, 2'b11, 1'b0, 0, 8'h0F);
    drive(0, 1'b1);

    // Two stop bits on the second instance.
    send(1, 8'h5A, 2'b11, 1'b0, 0, 8'h5A);
    send(1, 8'h96, 2'b01, 1'b0, 1, 8'h5A);
    drive(1, 1'b1);
    repeat (3) drive(1, 1'b1);
    #1;
    chk("stop2_busy_after", {31'd0, busy1}, 32'h0);
    chk("stop2_data_held", {24'd0, data1}, 32'h5A);

    // Reset in the middle of a frame of 0xFF.
    drive(0, 1'b0);
    repeat (4) drive(0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_data", {24'd0, data0}, 32'h0);
    chk("midreset_busy", {31'd0, busy0}, 32'h0);
    chk("midreset_valid", {31'd0, valid0}, 32'h0);
    d0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) drive(0, 1'b1);
    send(0, 8'h81, 2'b11, 1'b0, 0, 8'h81);
    drive(0, 1'b1);
    #1;
    chk("post_reset_data", {24'd0, data0}, 32'h81);
`ifdef DATA_IF_RX_PARITY_EN
    send(0, 8'h81, 2'b11, 1'b1, 2, 8'h81);
    drive(0, 1'b1);
    #1;
    chk("parity_data_held", {24'd0, data0}, 32'h81);
    chk("parity_busy_after", {31'd0, busy0}, 32'h0);
`endif

    repeat (15) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_if_rx.md
Name: data_if_rx

Overview:
- Serial receiver for the single-wire data_if stream: one data line `d`, sampled once per rising edge of `clk`.
- The bench and transmitter side drive `dif.d`. This block is the reading end.
- It detects a start bit, shifts in a WIDTH-bit word LSB first, checks the stop bits, and presents the word with a one-cycle valid pulse.
- It sits between a data_if instance and a word-level consumer or scoreboard.

Parameters:
- WIDTH, 8, data bits per frame; legal range 1..32.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  clock; `d` is sampled on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  1  serial line; idles high.
- data  output  WIDTH  last correctly received word.
- valid  output  1  one-cycle pulse; `data` is updated in the same cycle.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous and active-low. All state is registered on the rising edge of `clk`.
- Reset values: data=0, valid=0, frame_err=0, busy=0, state=IDLE, bit counter=0, shift register=0.
- Frame format, one bit per clock: start bit (0), then WIDTH data bits LSB first, then [parity bit, optional feature only], then STOP_BITS stop bits (1).
- Bit counter width is $clog2(WIDTH+1). The shift register shifts right, with the new bit entering at the MSB.
- IDLE:
  - d==0 sampled -> DATA, counter cleared, busy=1 from the next cycle.
  - d==1 -> stay in IDLE.
- DATA:
  - Each edge shifts `d` in and increments the counter.
  - After WIDTH bits -> STOP, or -> PARITY if the optional feature is enabled.
- STOP:
  - Sample STOP_BITS bits and record whether any sampled bit is 0.
  - After the last stop bit, if all stop bits were 1: valid=1 and data=shift register in the next cycle, then -> IDLE.
  - If any stop bit was 0: frame_err=1 in the next cycle, data unchanged, valid=0, then -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay while d==0 (break condition); a start bit is not accepted here.
  - d==1 -> IDLE.
- Latency: valid rises in the cycle after the edge that sampled the last stop bit.
- Back-to-back frames: a start bit in the cycle immediately after the last stop bit is accepted with no gap cycle. This holds because the move to IDLE and start detection line up on consecutive edges.
- Pulses: valid and frame_err are each high for exactly one cycle and are never high together.
- Reset mid-frame: returns immediately to the reset values; no partial word is output and no pulse is generated.
- X on `d`: undefined; the bench never drives X after reset.

Optional Feature:
- Macro: DATA_IF_RX_PARITY_EN.
- When defined:
  - An even-parity bit follows the data bits, and state PARITY samples it.
  - Output port `parity_err` (1 bit) is present, with reset value 0.
  - On mismatch: `parity_err` pulses for one cycle at the same point where valid would have pulsed, valid stays 0, data is unchanged, and the next state is IDLE.
  - Frame error has priority over parity error; only frame_err pulses in that case.
- When undefined:
  - There is no PARITY state and no `parity_err` port.
  - The frame is start + WIDTH data + STOP_BITS stop bits.

Test Plan:
1. Reset, then drive d=1 for 10 cycles -> valid, frame_err and busy stay 0; data=0.
2. WIDTH=8, send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> valid pulses for one cycle 10 cycles after the start edge; data=0xA5; busy low afterwards.
3. Send 0x3C and 0xC3 back-to-back with no idle cycle -> two valid pulses exactly 10 cycles apart; data=0x3C, then 0xC3.
4. Send 0x55 with stop bit 0, hold d=0 for 5 more cycles, then d=1, then send 0x0F -> frame_err pulses once, data stays 0x55's predecessor, no start is accepted during the low hold, and 0x0F is received with valid.
5. STOP_BITS=2, second stop bit 0 -> frame_err pulses for one cycle and valid=0.
6. Assert rst_n=0 after 4 data bits of 0xFF, release it, then send 0x81 -> no pulse during or after the reset; 0x81 is received correctly. With DATA_IF_RX_PARITY_EN, send 0x81 with parity bit 1 -> parity_err pulses and valid=0.
